// File: rtl/fpalu_seq_if.sv
// fpalu_seq_if: request/response bundle between FP control, fpalu_seq and the FP cores
// Ports (all grouped here, clock/reset stay on the module):
//   istart/oready        op valid / sequencer idle
//   icontrol, idataa/b   op code and operands from control
//   ocore_*              registered operands and op code towards the cores
//   icore_*              selected core result and status
//   odone, oresult, oCompResult, onan/ozero/ooverflow/ounderflow  captured result of the last op
//   oflags, iflags_clr   sticky {nan,overflow,underflow} and its clear
interface fpalu_seq_if #(parameter int WIDTH = 32);
    logic             istart;
    logic             oready;
    logic [4:0]       icontrol;
    logic [WIDTH-1:0] idataa;
    logic [WIDTH-1:0] idatab;
    logic [WIDTH-1:0] ocore_dataa;
    logic [WIDTH-1:0] ocore_datab;
    logic [4:0]       ocore_control;
    logic [WIDTH-1:0] icore_result;
    logic             icore_nan;
    logic             icore_zero;
    logic             icore_overflow;
    logic             icore_underflow;
    logic             icore_comp;
    logic             odone;
    logic [WIDTH-1:0] oresult;
    logic             oCompResult;
    logic             onan;
    logic             ozero;
    logic             ooverflow;
    logic             ounderflow;
    logic [2:0]       oflags;
    logic             iflags_clr;

    modport slave (
        input  istart, icontrol, idataa, idatab, icore_result, icore_nan, icore_zero,
               icore_overflow, icore_underflow, icore_comp, iflags_clr,
        output oready, ocore_dataa, ocore_datab, ocore_control, odone, oresult,
               oCompResult, onan, ozero, ooverflow, ounderflow, oflags
    );

    modport master (
        output istart, icontrol, idataa, idatab, icore_result, icore_nan, icore_zero,
               icore_overflow, icore_underflow, icore_comp, iflags_clr,
        input  oready, ocore_dataa, ocore_datab, ocore_control, odone, oresult,
               oCompResult, onan, ozero, ooverflow, ounderflow, oflags
    );
endinterface

// File: rtl/fpalu_seq.sv
// fpalu_seq: one-at-a-time FP op sequencer; holds core operands, counts core latency, captures results
// Ports: iclock (rising edge), ireset_n (async, active low), bus (fpalu_seq_if.slave, see interface)
module fpalu_seq #(
    parameter int WIDTH    = 32,
    parameter int LAT_ADD  = 7,
    parameter int LAT_MUL  = 5,
    parameter int LAT_DIV  = 6,
    parameter int LAT_SQRT = 16,
    parameter int LAT_CMP  = 1,
    parameter int LAT_CVT  = 6
) (
    input logic         iclock,
    input logic         ireset_n,
    fpalu_seq_if.slave  bus
);
    localparam logic [4:0] FOPADD   = 5'd0;
    localparam logic [4:0] FOPSUB   = 5'd1;
    localparam logic [4:0] FOPMUL   = 5'd2;
    localparam logic [4:0] FOPDIV   = 5'd3;
    localparam logic [4:0] FOPSQRT  = 5'd4;
    localparam logic [4:0] FOPABS   = 5'd5;
    localparam logic [4:0] FOPNEG   = 5'd6;
    localparam logic [4:0] FOPCEQ   = 5'd7;
    localparam logic [4:0] FOPCLT   = 5'd8;
    localparam logic [4:0] FOPCLE   = 5'd9;
    localparam logic [4:0] FOPCVTSW = 5'd10;
    localparam logic [4:0] FOPCVTWS = 5'd11;
    localparam logic [4:0] FOPSGNJ  = 5'd12;
    localparam logic [4:0] FOPSGNJN = 5'd13;
    localparam logic [4:0] FOPSGNJX = 5'd14;

    if (LAT_ADD < 1 || LAT_ADD > 31 || LAT_MUL < 1 || LAT_MUL > 31 || LAT_DIV < 1 || LAT_DIV > 31 ||
        LAT_SQRT < 1 || LAT_SQRT > 31 || LAT_CMP < 1 || LAT_CMP > 31 || LAT_CVT < 1 || LAT_CVT > 31)
    begin : g_lat_err
        $error("fpalu_seq: every LAT_* must be within 1..31");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [4:0]       cnt;
    logic [4:0]       lat;
    logic [WIDTH-1:0] sign_res;
    logic [WIDTH-1:0] res_nx;
    logic             is_core, is_cmp, accept, cap_core, cap_sign;
    logic             nan_nx, zero_nx, ovf_nx, unf_nx, comp_nx;

    // lat == 0 marks an op executed in-block (sign ops and unknown codes)
    always_comb begin
        lat      = 5'd0;
        sign_res = '0;
        case (bus.icontrol)
            FOPADD, FOPSUB:                 lat = 5'(LAT_ADD);
            FOPMUL:                         lat = 5'(LAT_MUL);
            FOPDIV:                         lat = 5'(LAT_DIV);
            FOPSQRT:                        lat = 5'(LAT_SQRT);
            FOPCEQ, FOPCLT, FOPCLE, FOPABS: lat = 5'(LAT_CMP);
            FOPCVTSW, FOPCVTWS:             lat = 5'(LAT_CVT);
            FOPNEG:   sign_res = {~bus.idataa[WIDTH-1], bus.idataa[WIDTH-2:0]};
            FOPSGNJ:  sign_res = {bus.idatab[WIDTH-1], bus.idataa[WIDTH-2:0]};
            FOPSGNJN: sign_res = {~bus.idatab[WIDTH-1], bus.idataa[WIDTH-2:0]};
            FOPSGNJX: sign_res = {bus.idataa[WIDTH-1] ^ bus.idatab[WIDTH-1], bus.idataa[WIDTH-2:0]};
            default: ;
        endcase
        is_core  = lat != 5'd0;
        accept   = bus.istart && state == IDLE;
        cap_core = state == WAIT && cnt == 5'd1;
        cap_sign = accept && !is_core;
        // the op in flight is the latched one, so decode capture details from ocore_control
        is_cmp   = bus.ocore_control inside {FOPCEQ, FOPCLT, FOPCLE};
        res_nx   = cap_core ? (is_cmp ? '0 : bus.icore_result) : sign_res;
        nan_nx   = cap_core && bus.icore_nan;
        ovf_nx   = cap_core && bus.icore_overflow;
        unf_nx   = cap_core && bus.icore_underflow;
        comp_nx  = cap_core && bus.icore_comp;
        zero_nx  = cap_core && (bus.ocore_control == FOPCVTWS ? bus.icore_result == '0 : bus.icore_zero);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (is_core ? WAIT : DONE) : IDLE;
            WAIT:    state_nx = cnt == 5'd1 ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
        bus.oready = state == IDLE;
        bus.odone  = state == DONE;
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            cnt               <= 5'd0;
            bus.ocore_dataa   <= '0;
            bus.ocore_datab   <= '0;
            bus.ocore_control <= 5'd0;
            bus.oresult       <= '0;
            bus.oCompResult   <= 1'b0;
            bus.onan          <= 1'b0;
            bus.ozero         <= 1'b0;
            bus.ooverflow     <= 1'b0;
            bus.ounderflow    <= 1'b0;
            bus.oflags        <= 3'b0;
        end else begin
            if (accept && is_core) begin
                bus.ocore_dataa   <= bus.idataa;
                bus.ocore_datab   <= bus.idatab;
                bus.ocore_control <= bus.icontrol;
                cnt               <= lat;
            end else if (state == WAIT) begin
                cnt <= cnt - 5'd1;
            end
            if (cap_core || cap_sign) begin
                bus.oresult     <= res_nx;
                bus.oCompResult <= comp_nx;
                bus.onan        <= nan_nx;
                bus.ozero       <= zero_nx;
                bus.ooverflow   <= ovf_nx;
                bus.ounderflow  <= unf_nx;
                // a clear on the capture edge keeps only the new op's flags
                bus.oflags      <= (bus.iflags_clr ? 3'b0 : bus.oflags) | {nan_nx, ovf_nx, unf_nx};
            end else if (bus.iflags_clr) begin
                bus.oflags <= 3'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpalu_seq.sv
// tb_fpalu_seq: randomized and directed self-checking bench for fpalu_seq against a behavioural model
module tb_fpalu_seq;
    localparam logic [4:0] FOPADD   = 5'd0;
    localparam logic [4:0] FOPSUB   = 5'd1;
    localparam logic [4:0] FOPMUL   = 5'd2;
    localparam logic [4:0] FOPDIV   = 5'd3;
    localparam logic [4:0] FOPSQRT  = 5'd4;
    localparam logic [4:0] FOPABS   = 5'd5;
    localparam logic [4:0] FOPNEG   = 5'd6;
    localparam logic [4:0] FOPCEQ   = 5'd7;
    localparam logic [4:0] FOPCLT   = 5'd8;
    localparam logic [4:0] FOPCLE   = 5'd9;
    localparam logic [4:0] FOPCVTSW = 5'd10;
    localparam logic [4:0] FOPCVTWS = 5'd11;
    localparam logic [4:0] FOPSGNJ  = 5'd12;
    localparam logic [4:0] FOPSGNJN = 5'd13;
    localparam logic [4:0] FOPSGNJX = 5'd14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;
    logic [2:0] exp_flags = 3'b0;

    always #5 clk = ~clk;

    fpalu_seq_if #(.WIDTH(32)) b0 ();
    fpalu_seq_if #(.WIDTH(32)) b1 ();
    fpalu_seq_if #(.WIDTH(32)) b2 ();

    fpalu_seq dut (.iclock(clk), .ireset_n(rst_n), .bus(b0.slave));
    fpalu_seq #(.LAT_SQRT(1))  dut_s1  (.iclock(clk), .ireset_n(rst_n), .bus(b1.slave));
    fpalu_seq #(.LAT_SQRT(31)) dut_s31 (.iclock(clk), .ireset_n(rst_n), .bus(b2.slave));

    assign b1.istart = b0.istart;             assign b2.istart = b0.istart;
    assign b1.icontrol = b0.icontrol;         assign b2.icontrol = b0.icontrol;
    assign b1.idataa = b0.idataa;             assign b2.idataa = b0.idataa;
    assign b1.idatab = b0.idatab;             assign b2.idatab = b0.idatab;
    assign b1.icore_result = b0.icore_result; assign b2.icore_result = b0.icore_result;
    assign b1.icore_nan = b0.icore_nan;       assign b2.icore_nan = b0.icore_nan;
    assign b1.icore_zero = b0.icore_zero;     assign b2.icore_zero = b0.icore_zero;
    assign b1.icore_overflow = b0.icore_overflow;   assign b2.icore_overflow = b0.icore_overflow;
    assign b1.icore_underflow = b0.icore_underflow; assign b2.icore_underflow = b0.icore_underflow;
    assign b1.icore_comp = b0.icore_comp;     assign b2.icore_comp = b0.icore_comp;
    assign b1.iflags_clr = b0.iflags_clr;     assign b2.iflags_clr = b0.iflags_clr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // core latency of an op in cycles, 0 for ops the sequencer resolves itself
    function automatic int lat_of(input logic [4:0] op);
        case (op)
            FOPADD, FOPSUB:                 return 7;
            FOPMUL:                         return 5;
            FOPDIV:                         return 6;
            FOPSQRT:                        return 16;
            FOPCEQ, FOPCLT, FOPCLE, FOPABS: return 1;
            FOPCVTSW, FOPCVTWS:             return 6;
            default:                        return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, b, cr);
        case (op)
            FOPNEG:                 return a ^ 32'h8000_0000;
            FOPSGNJ:                return (a & 32'h7fff_ffff) | (b & 32'h8000_0000);
            FOPSGNJN:               return (a & 32'h7fff_ffff) | (~b & 32'h8000_0000);
            FOPSGNJX:               return a ^ (b & 32'h8000_0000);
            FOPCEQ, FOPCLT, FOPCLE: return 32'h0;
            default:                return lat_of(op) != 0 ? cr : 32'h0;
        endcase
    endfunction

    // cf and result are {nan, zero, overflow, underflow, comp}
    function automatic logic [4:0] ref_flags(input logic [4:0] op, input logic [31:0] cr, input logic [4:0] cf);
        logic [4:0] f;
        if (lat_of(op) == 0)
            return 5'b0;
        f = cf;
        if (op == FOPCVTWS)
            f[3] = cr == 32'h0;
        return f;
    endfunction

    task automatic check_reset();
        chk("rst_result", b0.oresult, 0);
        chk("rst_core_ops", {b0.ocore_dataa, b0.ocore_datab}, 0);
        chk("rst_ctl", {b0.odone, b0.oCompResult, b0.onan, b0.ozero, b0.ooverflow, b0.ounderflow,
                        b0.oflags, b0.ocore_control}, 0);
        chk("rst_ready", b0.oready, 1);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, b, cr, input logic [4:0] cf,
                          input bit clr_cap, input bit poke);
        int         l;
        int         n;
        bit         seen;
        bit         ready_bad;
        logic [4:0] ef;
        l = lat_of(op) + 1;
        @(negedge clk);
        chk("ready_before", b0.oready, 1);
        b0.icontrol = op; b0.idataa = a; b0.idatab = b;
        b0.icore_result = cr;
        {b0.icore_nan, b0.icore_zero, b0.icore_overflow, b0.icore_underflow, b0.icore_comp} = cf;
        b0.istart = 1'b1;
        @(negedge clk);
        b0.istart = 1'b0;
        n = 1; seen = 0; ready_bad = 0;
        while (!seen && n <= 64) begin
            if (b0.oready) ready_bad = 1;
            if (n == 1 && l > 1)
                chk("core_latch", {b0.ocore_control, b0.ocore_dataa, b0.ocore_datab[26:0]}, {op, a, b[26:0]});
            if (b0.odone) begin
                seen = 1;
            end else begin
                if (clr_cap && l > 1 && n == l - 1) b0.iflags_clr = 1'b1;
                if (poke && n == 1) begin
                    b0.istart = 1'b1; b0.icontrol = FOPNEG; b0.idataa = $urandom;
                end
                @(negedge clk);
                n++;
            end
        end
        b0.iflags_clr = 1'b0;
        b0.istart = 1'b0;
        if (!seen) begin
            chk("done_timeout", n, l);
        end else begin
            ef = ref_flags(op, cr, cf);
            chk("latency", n, l);
            chk("result", b0.oresult, ref_res(op, a, b, cr));
            chk("op_flags", {b0.onan, b0.ozero, b0.ooverflow, b0.ounderflow, b0.oCompResult}, ef);
            chk("busy_ready", ready_bad, 0);
            exp_flags = ((clr_cap && l > 1) ? 3'b0 : exp_flags) | {ef[4], ef[2], ef[1]};
            chk("sticky", b0.oflags, exp_flags);
        end
        @(negedge clk);
        chk("done_once", {b0.odone, b0.oready}, 2'b01);
    endtask

    initial begin
        int d0, d1, d2, ndone;
        logic [4:0] op;
        b0.istart = 0; b0.icontrol = 0; b0.idataa = 0; b0.idatab = 0; b0.icore_result = 0;
        b0.icore_nan = 0; b0.icore_zero = 0; b0.icore_overflow = 0; b0.icore_underflow = 0;
        b0.icore_comp = 0; b0.iflags_clr = 0;
        #12;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // SQRT latency for default, LAT_SQRT=1 and LAT_SQRT=31 instances
        @(negedge clk);
        b0.icontrol = FOPSQRT; b0.idataa = 32'h4080_0000; b0.istart = 1'b1;
        @(negedge clk);
        b0.istart = 1'b0;
        d0 = 0; d1 = 0; d2 = 0;
        for (int n = 1; n <= 40; n++) begin
            if (b0.odone && d0 == 0) d0 = n;
            if (b1.odone && d1 == 0) d1 = n;
            if (b2.odone && d2 == 0) d2 = n;
            @(negedge clk);
        end
        chk("sqrt_lat16", d0, 17);
        chk("sqrt_lat1", d1, 2);
        chk("sqrt_lat31", d2, 32);

        run_op(FOPADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b0, 0, 0);
        run_op(FOPSGNJX, 32'h3F80_0000, 32'hBF80_0000, 32'h1234_5678, 5'b11111, 0, 0);
        run_op(FOPNEG, 32'h0000_0000, 32'h0, 32'h0, 5'b0, 0, 0);

        run_op(FOPDIV, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 5'b00100, 0, 0);
        run_op(FOPMUL, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00010, 0, 0);
        chk("sticky_ovf_unf", b0.oflags, 3'b011);
        run_op(FOPMUL, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00010, 1, 0);
        chk("sticky_clr_on_capture", b0.oflags, 3'b001);
        @(negedge clk);
        b0.iflags_clr = 1'b1;
        @(negedge clk);
        b0.iflags_clr = 1'b0;
        exp_flags = 3'b0;
        chk("flags_clr_idle", b0.oflags, exp_flags);

        run_op(FOPCLT, 32'h3F80_0000, 32'h4000_0000, 32'hFFFF_FFFF, 5'b00001, 0, 1);
        chk("clt_comp", {b0.oCompResult, b0.oresult}, {1'b1, 32'h0});

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 16));
            if (op > 5'd14) op = 5'($urandom_range(15, 31));
            run_op(op, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                   5'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // reset in the middle of a DIV aborts it without a done pulse
        @(negedge clk);
        b0.icontrol = FOPDIV; b0.idataa = $urandom; b0.icore_overflow = 1'b1; b0.istart = 1'b1;
        @(negedge clk);
        b0.istart = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset();
        exp_flags = 3'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (b0.odone) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_flags", b0.oflags, exp_flags);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
